// File: rtl/usb_tx_encoder_if.sv
// Handshake and line bundle between the shift register, the USB TX encoder and the line driver.
// With USB_TX_ABORT_EN defined the bundle also carries tx_abort.
interface usb_tx_encoder_if;
    logic tx_start;
    logic tx_bit;
    logic tx_last;
`ifdef USB_TX_ABORT_EN
    logic tx_abort;
`endif
    logic bit_req;
    logic busy;
    logic tx_oe;
    logic dp_out;
    logic dm_out;

    modport master (
        output tx_start,
        output tx_bit,
        output tx_last,
`ifdef USB_TX_ABORT_EN
        output tx_abort,
`endif
        input  bit_req,
        input  busy,
        input  tx_oe,
        input  dp_out,
        input  dm_out
    );

    modport slave (
        input  tx_start,
        input  tx_bit,
        input  tx_last,
`ifdef USB_TX_ABORT_EN
        input  tx_abort,
`endif
        output bit_req,
        output busy,
        output tx_oe,
        output dp_out,
        output dm_out
    );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB TX line stage: bit stuffing, NRZI encoding and EOP generation.
// Optional abort sequence (eight unstuffed ones, then EOP) is enabled by USB_TX_ABORT_EN.
//
// state   | meaning
// IDLE    | line J, driver off, waiting for tx_start
// DATA    | each boundary consumes one data bit (bit_req) and emits it NRZI
// STUFF   | boundary emits the stuffed zero; no data bit consumed
// EOP_SE0 | boundaries emit SE0 for EOP_SE0_BITS bit times, then J
// EOP_J   | J on the line; boundary returns to IDLE and releases the driver
// ABORT   | seven further held (one) bit times, then EOP
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LIMIT  = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input logic              clk,
    input logic              rst,
    usb_tx_encoder_if.slave  bus
);
    localparam int TMR_W  = $clog2(CLKS_PER_BIT);
    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
    localparam int AUX_W  = $clog2(EOP_SE0_BITS + 8);

    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [ONES_W-1:0] ONES_LIM   = ONES_W'(STUFF_LIMIT);
    localparam logic [AUX_W-1:0]  EOP_LAST   = AUX_W'(EOP_SE0_BITS);
    localparam logic [AUX_W-1:0]  ABORT_LAST = AUX_W'(6);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA    = 3'd1,
        STUFF   = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
`ifdef USB_TX_ABORT_EN
        , ABORT = 3'd5
`endif
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [ONES_W-1:0] ones;
    logic [AUX_W-1:0]  aux;
    logic              last_flag;
    logic              dp;
    logic              dm;
    logic              oe;
    logic              busy_r;
    logic              boundary;
    logic              abort;
    logic [ONES_W-1:0] ones_inc;

`ifdef USB_TX_ABORT_EN
    assign abort = bus.tx_abort;
`else
    assign abort = 1'b0;
`endif

    assign boundary    = (timer == TMR_LAST);
    assign ones_inc    = ones + ONES_W'(1);
    assign bus.bit_req = (state == DATA) && boundary && !abort;
    assign bus.dp_out  = dp;
    assign bus.dm_out  = dm;
    assign bus.tx_oe   = oe;
    assign bus.busy    = busy_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            ones      <= '0;
            aux       <= '0;
            last_flag <= 1'b0;
            dp        <= 1'b1;
            dm        <= 1'b0;
            oe        <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            if (state != IDLE)
                timer <= boundary ? '0 : timer + TMR_W'(1);
            case (state)
                IDLE: begin
                    if (bus.tx_start) begin
                        state     <= DATA;
                        timer     <= '0;
                        ones      <= '0;
                        aux       <= '0;
                        last_flag <= 1'b0;
                        oe        <= 1'b1;
                        busy_r    <= 1'b1;
                        dp        <= 1'b1;
                        dm        <= 1'b0;
                    end
                end
                DATA: begin
                    if (boundary) begin
`ifdef USB_TX_ABORT_EN
                        if (abort) begin
                            state <= ABORT;
                            aux   <= '0;
                        end else
`endif
                        begin
                            // NRZI: a zero toggles the line, a one holds it
                            if (!bus.tx_bit) begin
                                dp   <= ~dp;
                                dm   <= ~dm;
                                ones <= '0;
                            end else begin
                                ones <= ones_inc;
                            end
                            if (bus.tx_bit && ones_inc == ONES_LIM) begin
                                state     <= STUFF;
                                last_flag <= bus.tx_last;
                            end else if (bus.tx_last) begin
                                state <= EOP_SE0;
                                aux   <= '0;
                            end
                        end
                    end
                end
                STUFF: begin
                    if (boundary) begin
`ifdef USB_TX_ABORT_EN
                        if (abort) begin
                            state <= ABORT;
                            aux   <= '0;
                        end else
`endif
                        begin
                            dp    <= ~dp;
                            dm    <= ~dm;
                            ones  <= '0;
                            aux   <= '0;
                            state <= last_flag ? EOP_SE0 : DATA;
                        end
                    end
                end
`ifdef USB_TX_ABORT_EN
                ABORT: begin
                    if (boundary) begin
                        if (aux == ABORT_LAST) begin
                            state <= EOP_SE0;
                            aux   <= '0;
                        end else begin
                            aux <= aux + AUX_W'(1);
                        end
                    end
                end
`endif
                EOP_SE0: begin
                    // First bit time of this state still shows the final bit
                    if (boundary) begin
                        if (aux == EOP_LAST) begin
                            dp    <= 1'b1;
                            dm    <= 1'b0;
                            state <= EOP_J;
                        end else begin
                            dp  <= 1'b0;
                            dm  <= 1'b0;
                            aux <= aux + AUX_W'(1);
                        end
                    end
                end
                EOP_J: begin
                    if (boundary) begin
                        state  <= IDLE;
                        oe     <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench for usb_tx_encoder: per-bit-time line levels are predicted and queued at
// stimulus time, then popped and compared mid-bit; bit_req timing and count are also checked.
module tb_usb_tx_encoder;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LSE0 = 2'b00;

    logic clk;
    logic rst;
    int   passed;
    int   total;
    logic [1:0] exp_q[$];

    usb_tx_encoder_if bus ();

    usb_tx_encoder #(
        .CLKS_PER_BIT (8),
        .STUFF_LIMIT  (6),
        .EOP_SE0_BITS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_packet(input string name, input logic [31:0] data, input int nbits,
                              input int abort_at, input bit dup_start);
        logic [1:0] lvl;
        logic [1:0] e;
        logic [3:0] got;
        int ones;
        int nb;
        int req_exp;
        int nreq;
        int idx;
        int len;
        bit req;
        exp_q.delete();
        lvl = LJ;
        exp_q.push_back(LJ);
        ones = 0;
        nb = 0;
        req_exp = 0;
        for (int i = 0; i < nbits; i++) begin
            nb++;
            if (abort_at != 0 && nb == abort_at) begin
                repeat (8) exp_q.push_back(lvl);
                break;
            end
            if (!data[i]) begin
                lvl = ~lvl;
                ones = 0;
            end else begin
                ones++;
            end
            exp_q.push_back(lvl);
            req_exp++;
            if (ones == 6) begin
                nb++;
                lvl = ~lvl;
                exp_q.push_back(lvl);
                ones = 0;
            end
        end
        exp_q.push_back(LSE0);
        exp_q.push_back(LSE0);
        exp_q.push_back(LJ);

        bus.tx_start = 1'b1;
        bus.tx_bit   = data[0];
        bus.tx_last  = (nbits == 1);
        @(negedge clk);
        bus.tx_start = 1'b0;
        len  = exp_q.size();
        nreq = 0;
        idx  = 0;
        for (int n = 0; n < 8 * len + 6; n++) begin
            req = bus.bit_req;
            got = {bus.tx_oe, bus.busy, bus.dp_out, bus.dm_out};
            if (n % 8 == 4 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (got !== {2'b11, e})
                    $display("FAIL %s line bit %0d: oe/busy/dp/dm got %b want %b", name, n / 8, got, {2'b11, e});
                else
                    passed++;
            end
            if (n == 8 * len + 4) begin
                total++;
                if (got !== 4'b0010)
                    $display("FAIL %s idle after EOP: oe/busy/dp/dm got %b want 0010", name, got);
                else
                    passed++;
            end
            if (req) begin
                nreq++;
                total++;
                if (n % 8 != 7)
                    $display("FAIL %s bit_req phase: got cycle %0d of bit want 7", name, n % 8);
                else
                    passed++;
            end
            bus.tx_bit   = (idx < nbits) ? data[idx] : 1'b0;
            bus.tx_last  = (idx == nbits - 1);
            bus.tx_start = dup_start && (n == 20);
`ifdef USB_TX_ABORT_EN
            bus.tx_abort = (abort_at != 0) && (n / 8 == abort_at - 1);
`endif
            if (req) idx++;
            @(negedge clk);
        end
        total++;
        if (nreq != req_exp)
            $display("FAIL %s bit_req count: got %0d want %0d", name, nreq, req_exp);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.dp_out, bus.dm_out, bus.tx_oe, bus.busy, bus.bit_req} !== 5'b10000)
            $display("FAIL reset state: dp/dm/oe/busy/req got %b want 10000",
                     {bus.dp_out, bus.dm_out, bus.tx_oe, bus.busy, bus.bit_req});
        else
            passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        bus.tx_start = 1'b1;
        bus.tx_bit   = 1'b0;
        bus.tx_last  = 1'b0;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (bus.tx_oe !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL mid_reset precondition: oe/busy got %b%b want 11", bus.tx_oe, bus.busy);
        else
            passed++;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.dp_out, bus.dm_out, bus.tx_oe, bus.busy, bus.bit_req} !== 5'b10000)
            $display("FAIL mid_reset state: dp/dm/oe/busy/req got %b want 10000",
                     {bus.dp_out, bus.dm_out, bus.tx_oe, bus.busy, bus.bit_req});
        else
            passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sync();
        run_packet("sync", 32'h0000_0080, 8, 0, 1'b0);
    endtask

    task automatic test_stuff_mid();
        run_packet("stuff_mid", 32'h0000_01FE, 9, 0, 1'b0);
    endtask

    task automatic test_stuff_last();
        run_packet("stuff_last", 32'h0000_01FA, 9, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_packet("busy_start", 32'h0000_00B4, 8, 0, 1'b1);
        run_packet("b2b", 32'h0000_3C5A, 16, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] d;
        int nb;
        for (int k = 0; k < 3; k++) begin
            d  = $urandom;
            nb = $urandom_range(4, 20);
            run_packet("random", d, nb, 0, 1'b0);
        end
    endtask

`ifdef USB_TX_ABORT_EN
    task automatic test_abort();
        run_packet("abort", 32'h0000_00F2, 8, 3, 1'b0);
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        rst          = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_bit   = 1'b0;
        bus.tx_last  = 1'b0;
`ifdef USB_TX_ABORT_EN
        bus.tx_abort = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_mid_reset();
        test_sync();
        test_stuff_mid();
        test_stuff_last();
        test_back_to_back();
        test_random();
`ifdef USB_TX_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
- Downstream TX line stage fed by the parallel-load shift register. Pulls one serial bit per USB bit time from the shift register's serial_out, inserts a stuffed zero after STUFF_LIMIT consecutive ones, NRZI-encodes onto dp_out/dm_out, and closes the packet with EOP (SE0 then J).
- bit_req drives the shift register's shift_enable. It is withheld during stuffed bits and EOP so no data bit is lost.

Parameters:
CLKS_PER_BIT, 8, system clocks per USB bit time (min 2)
STUFF_LIMIT, 6, consecutive ones before a stuffed zero is inserted
EOP_SE0_BITS, 2, bit times of SE0 in EOP

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  reset; one clock; reset is synchronous and active-high
tx_start  input  1  one-cycle pulse; begin packet (ignored while busy)
tx_bit  input  1  current data bit (shift register serial_out, LSB first)
tx_last  input  1  qualifies tx_bit as final data bit; sampled only with tx_bit
bit_req  output  1  one-cycle pulse: tx_bit consumed; advance shift register
busy  output  1  high from cycle after tx_start until EOP J bit completes
tx_oe  output  1  line driver enable
dp_out  output  1  D+ level
dm_out  output  1  D- level

Behaviour:
- Line states: J = dp1/dm0, K = dp0/dm1, SE0 = dp0/dm0. dp_out, dm_out, tx_oe, busy are registered. bit_req is combinational from state and counter.
- Reset (rst high at posedge):
  - state IDLE, dp_out=1, dm_out=0, tx_oe=0, busy=0, bit_req=0.
  - bit counter 0, ones counter 0, last flag 0.
  - Applies mid-packet too: line returns to idle J at the next edge, with no EOP.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and wraps; width $clog2(CLKS_PER_BIT).
  - Boundary cycle = count CLKS_PER_BIT-1. Line outputs change only at the edge ending a boundary cycle.
- States: IDLE, DATA, STUFF, EOP_SE0, EOP_J.
- IDLE:
  - On tx_start: next edge goes to DATA, tx_oe=1, busy=1, timer=0, ones=0, line held J.
  - The first data bit therefore appears after CLKS_PER_BIT clocks.
- DATA, boundary cycle:
  - bit_req=1. Sample tx_bit and tx_last.
  - 0 bit: toggle J/K, ones=0.
  - 1 bit: hold level, ones+1.
  - Next state:
    - if new ones == STUFF_LIMIT: STUFF, with last flag := tx_last;
    - else if tx_last: EOP_SE0;
    - else stay in DATA.
- STUFF, boundary cycle:
  - bit_req=0. Toggle line (stuffed 0), ones=0.
  - Next state is EOP_SE0 if last flag set, else DATA.
  - A stuff bit after the final data bit is mandatory.
- EOP_SE0: line SE0 for EOP_SE0_BITS bit times; a bit-time counter counts boundaries. Then EOP_J.
- EOP_J: line J for one bit time. At its boundary: IDLE, tx_oe=0, busy=0 at that edge.
- Edge and ignored-input rules:
  - tx_start outside IDLE is ignored.
  - tx_last outside DATA boundary cycles is ignored.
  - tx_bit is don't-care except in DATA boundary cycles.
- Handshake timing:
  - Shift register updates at the edge ending the bit_req cycle. tx_bit is valid at least CLKS_PER_BIT-1 clocks before the next sample.
  - Upstream loads (load_enable) only while busy=0, or in the same cycle as bit_req for the last bit of a byte.

Optional Feature:
- Macro USB_TX_ABORT_EN.
- Defined:
  - Adds input tx_abort (1 bit) and state ABORT.
  - tx_abort high in a DATA or STUFF boundary cycle: that boundary emits a 1 (hold level, no bit_req), then ABORT.
  - ABORT emits seven more 1 bits, unstuffed, no transitions, no bit_req, so 8 total. Then EOP_SE0 → EOP_J → IDLE.
  - tx_abort has priority over tx_last and over a pending stuff.
- Undefined: port and ABORT state absent; behaviour exactly as above.

Test Plan:
1. rst high 2 cycles mid-DATA → next edge dp=1, dm=0, tx_oe=0, busy=0, bit_req=0; tx_start afterwards yields a normal packet.
2. tx_start, bits 0,0,0,0,0,0,0,1 (SYNC 0x80 LSB first), tx_last on 8th → line after J idle bit: K J K J K J K K. Then SE0 for 16 clocks, J 8 clocks, tx_oe low. 8 bit_req pulses spaced 8 clocks (CLKS_PER_BIT=8).
3. Eight 1s after a K start, tx_last on 8th → stuffed toggle after the 6th one; bit_req absent in that bit time. Total 9 data bit times before SE0.
4. Data ending with exactly six 1s and tx_last → stuff toggle bit time, then SE0 2 bit times, J 1 bit time; 6 bit_req pulses for those bits.
5. tx_start pulsed while busy → ignored; packet bit count and EOP timing unchanged, busy stays 1.
6. (USB_TX_ABORT_EN) tx_abort at 3rd boundary → no transitions for 8 bit times, no further bit_req, then SE0 2 bit times, J, idle.
